// File: rtl/iteration_frame_writer.sv
`timescale 1ns/1ps
// iteration_frame_writer
//   Sits behind the Mandelbrot engine. Requests bursts of iteration counts
//   over the engine's ready/send_data handshake, buffers them in a FIFO,
//   maps each count to 24-bit RGB and writes pixels sequentially to the
//   frame-buffer write port. Once a whole frame is written it pulses
//   clear_frame back to the engine.
// Ports
//   CLK, SYS_RESET          clock, synchronous active-high reset
//   update, resolution      latch frame size and flush all frame state
//   engine_ready            engine can accept a burst request
//   engine_data             iteration word from engine
//   frame_ready             engine frame_ready, gates clear_frame
//   send_data               one-cycle burst request
//   clear_frame             one-cycle pulse: frame fully written
//   wr_en/wr_addr/wr_data   frame-buffer write request
//   wr_ack                  write accepted this cycle
//   frame_done              last pixel accepted, waiting for clear_frame
module iteration_frame_writer #(
  parameter int unsigned SET_SIZE   = 1,
  parameter int unsigned HBI        = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_ITER   = 255
) (
  input  logic           CLK,
  input  logic           SYS_RESET,
  input  logic           update,
  input  logic [3:0]     resolution,
  input  logic           engine_ready,
  input  logic [HBI-1:0] engine_data,
  input  logic           frame_ready,
  output logic           send_data,
  output logic           clear_frame,
  output logic           wr_en,
  output logic [20:0]    wr_addr,
  output logic [23:0]    wr_data,
  input  logic           wr_ack,
  output logic           frame_done
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1;

  localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  SET_C     = CW'(SET_SIZE);
  localparam logic [RW-1:0]  LAST_BEAT = RW'(SET_SIZE - 1);
  localparam logic [HBI-1:0] MAX_C     = HBI'(MAX_ITER);

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t         state;
  logic [RW-1:0]  beat;
  logic [HBI-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic [20:0]    addr;
  logic [20:0]    total_pixels;
  logic [20:0]    res_pixels;
  logic [HBI-1:0] head;
  logic           push;
  logic           pop;

  // The request cycle itself is spent in RECV with send_data still high;
  // data arrives from the following cycle on.
  assign push = (state == S_RECV) && !send_data;
  assign pop  = wr_en && wr_ack;

  assign head        = mem[rd_ptr];
  assign wr_en       = (count != '0) && !frame_done;
  assign wr_addr     = addr;
  assign clear_frame = frame_done && frame_ready;

  always_comb begin
    wr_data = '0;
    if (head < MAX_C)
      wr_data = {head[7:0], head[6:0], 1'b0, 8'hFF - head[7:0]};
  end

  always_comb begin
    case (resolution)
      4'b0001: res_pixels = 21'd480000;
      4'b0011: res_pixels = 21'd786432;
      4'b0010: res_pixels = 21'd921600;
      4'b1000: res_pixels = 21'd1310720;
      default: res_pixels = 21'd307200;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= engine_data;
  end

  always_ff @(posedge CLK) begin
    if (SYS_RESET) begin
      state        <= S_IDLE;
      beat         <= '0;
      send_data    <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      addr         <= '0;
      frame_done   <= 1'b0;
      total_pixels <= 21'd307200;
    end else if (update) begin
      state        <= S_IDLE;
      beat         <= '0;
      send_data    <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      addr         <= '0;
      frame_done   <= 1'b0;
      total_pixels <= res_pixels;
    end else begin
      case (state)
        S_IDLE: begin
          if (engine_ready && ((DEPTH_C - count) >= SET_C) && !frame_done) begin
            send_data <= 1'b1;
            beat      <= '0;
            state     <= S_RECV;
          end
        end
        S_RECV: begin
          if (send_data) begin
            send_data <= 1'b0;
          end else if (beat == LAST_BEAT) begin
            state <= S_IDLE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (push)
        wr_ptr <= wr_ptr + 1'b1;

      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;

      // wr_en is gated by frame_done, so an accept never coincides with close.
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (addr == total_pixels - 21'd1) begin
          addr       <= '0;
          frame_done <= 1'b1;
        end else begin
          addr <= addr + 1'b1;
        end
      end else if (frame_done && frame_ready) begin
        frame_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iteration_frame_writer.sv
`timescale 1ns/1ps
module tb_iteration_frame_writer;

  logic        CLK = 1'b0;
  logic        SYS_RESET;
  logic [3:0]  resolution;
  logic [31:0] engine_data;
  logic        frame_ready;

  // Default instance: SET_SIZE=1, FIFO_DEPTH=16
  logic        update, engine_ready, wr_ack;
  logic        send_data, clear_frame, wr_en, frame_done;
  logic [20:0] wr_addr;
  logic [23:0] wr_data;

  // Burst instance: SET_SIZE=4, FIFO_DEPTH=4
  logic        update4, engine_ready4, wr_ack4;
  logic        send_data4, clear_frame4, wr_en4, frame_done4;
  logic [20:0] wr_addr4;
  logic [23:0] wr_data4;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  iteration_frame_writer dut (
    .CLK(CLK), .SYS_RESET(SYS_RESET), .update(update), .resolution(resolution),
    .engine_ready(engine_ready), .engine_data(engine_data), .frame_ready(frame_ready),
    .send_data(send_data), .clear_frame(clear_frame), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .frame_done(frame_done)
  );

  iteration_frame_writer #(.SET_SIZE(4), .HBI(32), .FIFO_DEPTH(4), .MAX_ITER(255)) dut4 (
    .CLK(CLK), .SYS_RESET(SYS_RESET), .update(update4), .resolution(resolution),
    .engine_ready(engine_ready4), .engine_data(engine_data), .frame_ready(frame_ready),
    .send_data(send_data4), .clear_frame(clear_frame4), .wr_en(wr_en4),
    .wr_addr(wr_addr4), .wr_data(wr_data4), .wr_ack(wr_ack4), .frame_done(frame_done4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // Request one word from the default instance; returns after it is in the FIFO.
  task automatic push_word(input logic [31:0] d);
    int n;
    engine_data  = d;
    engine_ready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!send_data && n < 20);
    check("req_seen", 32'(send_data), 32'd1);
    engine_ready = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int n;
    int sends;
    int seen;
    SYS_RESET = 1'b1; resolution = 4'b0000; engine_data = '0; frame_ready = 1'b0;
    update = 1'b0; engine_ready = 1'b0; wr_ack = 1'b0;
    update4 = 1'b0; engine_ready4 = 1'b0; wr_ack4 = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_send", 32'(send_data), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_clear", 32'(clear_frame), 32'd0);
    check("rst_wr_en4", 32'(wr_en4), 32'd0);
    SYS_RESET = 1'b0;

    // 1: single request, latency and colour of 5
    engine_data = 32'd5; engine_ready = 1'b1;
    tick();
    check("t1_send", 32'(send_data), 32'd1);
    check("t1_wr_en_S", 32'(wr_en), 32'd0);
    engine_ready = 1'b0;
    tick();
    check("t1_send_once", 32'(send_data), 32'd0);
    check("t1_wr_en_S1", 32'(wr_en), 32'd0);
    tick();
    check("t1_wr_en", 32'(wr_en), 32'd1);
    check("t1_addr", 32'(wr_addr), 32'd0);
    check("t1_data", 32'(wr_data), 32'h050AFA);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    check("t1_drained", 32'(wr_en), 32'd0);
    check("t1_addr_inc", 32'(wr_addr), 32'd1);

    // 2: in-set and zero colours
    push_word(32'd255);
    check("t2_black", 32'(wr_data), 32'h000000);
    check("t2_addr", 32'(wr_addr), 32'd1);
    push_word(32'd0);
    check("t2_head_kept", 32'(wr_data), 32'h000000);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    check("t2_zero", 32'(wr_data), 32'h0000FF);
    check("t2_addr2", 32'(wr_addr), 32'd2);

    // 5: hold without ack, then simultaneous push and pop
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_hold_en", 32'(wr_en), 32'd1);
      check("t5_hold_addr", 32'(wr_addr), 32'd2);
      check("t5_hold_data", 32'(wr_data), 32'h0000FF);
    end
    engine_data = 32'd16; engine_ready = 1'b1; n = 0;
    do begin tick(); n++; end while (!send_data && n < 20);
    check("t5_req", 32'(send_data), 32'd1);
    engine_ready = 1'b0;
    tick();
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    check("t5_pp_en", 32'(wr_en), 32'd1);
    check("t5_pp_addr", 32'(wr_addr), 32'd3);
    check("t5_pp_data", 32'(wr_data), 32'h1020EF);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    check("t5_pp_count1", 32'(wr_en), 32'd0);
    check("t5_addr4", 32'(wr_addr), 32'd4);

    // 4: VGA wrap (address preloaded near the end of the frame)
    force dut.addr = 21'd307198;
    #1;
    release dut.addr;
    check("t4_preload", 32'(wr_addr), 32'd307198);
    push_word(32'd7);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    check("t4_addr_last", 32'(wr_addr), 32'd307199);
    check("t4_not_done", 32'(frame_done), 32'd0);
    push_word(32'd8);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    check("t4_wrap_addr", 32'(wr_addr), 32'd0);
    check("t4_done", 32'(frame_done), 32'd1);
    check("t4_wr_en_off", 32'(wr_en), 32'd0);
    check("t4_no_clear", 32'(clear_frame), 32'd0);
    engine_ready = 1'b1; sends = 0;
    repeat (6) begin tick(); if (send_data) sends++; end
    check("t4_stall_sends", 32'(sends), 32'd0);
    check("t4_still_done", 32'(frame_done), 32'd1);
    frame_ready = 1'b1;
    #1;
    check("t4_clear", 32'(clear_frame), 32'd1);
    tick();
    check("t4_clear_once", 32'(clear_frame), 32'd0);
    check("t4_done_low", 32'(frame_done), 32'd0);
    sends = 0;
    repeat (4) begin tick(); if (send_data) sends++; end
    check("t4_resume", 32'(sends != 0), 32'd1);
    frame_ready = 1'b0; engine_ready = 1'b0;
    repeat (4) tick();

    // 3: burst instance, FIFO space gating with no acks
    engine_data = 32'd9; engine_ready4 = 1'b1; sends = 0;
    repeat (12) begin tick(); if (send_data4) sends++; end
    check("t3_one_burst", 32'(sends), 32'd1);
    check("t3_wr_en", 32'(wr_en4), 32'd1);
    check("t3_addr", 32'(wr_addr4), 32'd0);
    check("t3_data", 32'(wr_data4), 32'h0912F6);
    wr_ack4 = 1'b1; tick(); wr_ack4 = 1'b0;
    sends = 0;
    repeat (8) begin tick(); if (send_data4) sends++; end
    check("t3_one_free_no_req", 32'(sends), 32'd0);
    check("t3_addr1", 32'(wr_addr4), 32'd1);
    engine_ready4 = 1'b0;
    wr_ack4 = 1'b1; repeat (3) tick(); wr_ack4 = 1'b0;
    check("t3_addr4", 32'(wr_addr4), 32'd4);
    check("t3_empty", 32'(wr_en4), 32'd0);
    engine_ready4 = 1'b1;
    tick();
    check("t3_req_when_free", 32'(send_data4), 32'd1);

    // 6: update mid-burst to SVGA
    tick();
    tick();
    update4 = 1'b1; resolution = 4'b0001; engine_ready4 = 1'b0;
    tick();
    update4 = 1'b0;
    check("t6_flush_en", 32'(wr_en4), 32'd0);
    check("t6_addr0", 32'(wr_addr4), 32'd0);
    check("t6_send_low", 32'(send_data4), 32'd0);
    seen = 0;
    repeat (4) begin tick(); if (wr_en4) seen++; end
    check("t6_burst_dropped", 32'(seen), 32'd0);
    force dut4.addr = 21'd479998;
    #1;
    release dut4.addr;
    engine_data = 32'd3; engine_ready4 = 1'b1; n = 0;
    do begin tick(); n++; end while (!send_data4 && n < 20);
    check("t6_req", 32'(send_data4), 32'd1);
    engine_ready4 = 1'b0;
    repeat (5) tick();
    check("t6_pre_addr", 32'(wr_addr4), 32'd479998);
    check("t6_data", 32'(wr_data4), 32'h0306FC);
    wr_ack4 = 1'b1; tick(); tick(); wr_ack4 = 1'b0;
    check("t6_wrap_addr", 32'(wr_addr4), 32'd0);
    check("t6_done", 32'(frame_done4), 32'd1);
    check("t6_wr_en_off", 32'(wr_en4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
